// File: rtl/vga_fetch_arbiter.sv
// Arbitrates one single-port framebuffer RAM between the scanline fetch
// (strict priority, one word per clock into the line buffer) and a host port.
module vga_fetch_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int WORDS  = 50,
  parameter int LB_AW  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic [9:0]        fetch_line,
  input  logic              fetch_deadline,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [LB_AW-1:0]  lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              underrun
);

  // Host handshake: a request is held stable with host_valid=1 until the cycle
  // host_ready=1; that cycle is the transfer. Reads return data with a
  // single-cycle host_rvalid pulse on the following cycle.

  typedef enum logic {IDLE, FETCH} state_t;

  localparam logic [LB_AW-1:0] LAST = LB_AW'(WORDS - 1);

  state_t            state, state_nxt;
  logic [LB_AW-1:0]  cnt, cnt_nxt, tag, rd_tag;
  logic [ADDR_W-1:0] line_base, start_base;
  logic              fetch_rd, rd_valid, rd_last, host_rd_pend;

  // Line offset is computed wide and truncated, so it wraps modulo 2**ADDR_W.
  assign start_base = base_addr + ADDR_W'(fetch_line * WORDS);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    fetch_rd   = 1'b0;
    tag        = cnt;
    host_ready = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    underrun   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (fetch_start) begin
            // First word issues immediately from the unlatched line address.
            fetch_rd = 1'b1;
            tag      = '0;
            mem_en   = 1'b1;
            mem_addr = start_base;
            cnt_nxt  = LB_AW'(1);
            if (LAST != '0) state_nxt = FETCH;
          end else if (host_valid) begin
            host_ready = 1'b1;
            mem_en     = 1'b1;
            mem_we     = host_we;
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
          end
        end
        FETCH: begin
          fetch_rd = 1'b1;
          tag      = cnt;
          mem_en   = 1'b1;
          mem_addr = line_base + ADDR_W'(cnt);
          cnt_nxt  = cnt + LB_AW'(1);
          if (cnt == LAST) begin
            state_nxt = IDLE;
          end else if (fetch_deadline) begin
            underrun  = 1'b1;
            state_nxt = IDLE;
          end
          if (fetch_start) underrun = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      line_base    <= '0;
      rd_valid     <= 1'b0;
      rd_tag       <= '0;
      rd_last      <= 1'b0;
      host_rd_pend <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      if (state == IDLE && fetch_start) line_base <= start_base;
      rd_valid     <= fetch_rd;
      rd_tag       <= tag;
      rd_last      <= fetch_rd && (tag == LAST);
      host_rd_pend <= host_ready && !host_we;
    end
  end

  // Read tags return one cycle later alongside mem_rdata.
  assign lb_we       = rd_valid && !reset;
  assign lb_addr     = lb_we ? rd_tag : '0;
  assign lb_wdata    = lb_we ? mem_rdata : '0;
  assign fetch_done  = lb_we && rd_last;
  assign host_rvalid = host_rd_pend && !reset;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;
  assign fetch_busy  = (state == FETCH) && !reset;

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Directed bench for vga_fetch_arbiter: RAM model plus cycle-by-cycle
// expectations for fetch, host access, deadline, wrap and reset cases.
module tb_vga_fetch_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int WORDS  = 50;
  localparam int LB_AW  = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_start;
  logic [9:0]        fetch_line;
  logic              fetch_deadline;
  logic [ADDR_W-1:0] base_addr;
  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              lb_we;
  logic [LB_AW-1:0]  lb_addr;
  logic [DATA_W-1:0] lb_wdata;
  logic              fetch_busy;
  logic              fetch_done;
  logic              underrun;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] ram [0:4095];

  vga_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .LB_AW(LB_AW)) dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .fetch_line(fetch_line),
    .fetch_deadline(fetch_deadline), .base_addr(base_addr), .host_valid(host_valid),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  function automatic logic [15:0] pat(input logic [11:0] a);
    return {4'hC, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // d: deadline cycle (-1 none); rs: repeated fetch_start cycle (-1 none);
  // hold: host read at haddr held from cycle 0, expecting hdata.
  task automatic run_fetch(input logic [11:0] base, input logic [9:0] line,
                           input logic [11:0] start, input int d, input int rs,
                           input bit hold, input logic [11:0] haddr,
                           input logic [15:0] hdata);
    int n;
    logic [11:0] a;
    n = (d >= 1 && d <= 48) ? d + 1 : 50;
    base_addr = base; fetch_line = line;
    host_we = 1'b0; host_addr = haddr; host_wdata = '0;
    for (int k = 0; k <= n + 1; k++) begin
      fetch_start    = (k == 0) || (k == rs);
      fetch_deadline = (k == d);
      host_valid     = hold && (k <= n);
      @(negedge clk);
      chk("fetch_busy", 32'(fetch_busy), 32'(k >= 1 && k < n));
      chk("underrun", 32'(underrun),
          32'((k == d && d >= 1 && d <= 48) || (k == rs && rs >= 1 && rs < n)));
      chk("fetch_done", 32'(fetch_done), 32'(n == 50 && k == 50));
      chk("host_ready", 32'(host_ready), 32'(hold && k == n));
      chk("host_rvalid", 32'(host_rvalid), 32'(hold && k == n + 1));
      if (hold && k == n + 1) chk("host_rdata", 32'(host_rdata), 32'(hdata));
      chk("mem_en", 32'(mem_en), 32'(k < n || (hold && k == n)));
      if (k < n) begin
        a = start + 12'(k);
        chk("fetch_addr", 32'(mem_addr), 32'(a));
        chk("fetch_we", 32'(mem_we), 32'(0));
      end
      if (hold && k == n) chk("host_addr", 32'(mem_addr), 32'(haddr));
      chk("lb_we", 32'(lb_we), 32'(k >= 1 && k <= n));
      if (k >= 1 && k <= n) begin
        a = start + 12'(k - 1);
        chk("lb_addr", 32'(lb_addr), 32'(k - 1));
        chk("lb_wdata", 32'(lb_wdata), 32'(pat(a)));
      end
      step();
    end
    fetch_start = 1'b0; fetch_deadline = 1'b0; host_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = pat(12'(i));
    reset = 1'b1; fetch_start = 1'b0; fetch_line = '0; fetch_deadline = 1'b0;
    base_addr = '0; host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    step(); step();

    // Outputs stay quiet under reset even with requests present.
    host_valid = 1'b1; host_we = 1'b1; fetch_start = 1'b1;
    @(negedge clk);
    chk("rst_host_ready", 32'(host_ready), 32'(0));
    chk("rst_mem_en", 32'(mem_en), 32'(0));
    chk("rst_lb_we", 32'(lb_we), 32'(0));
    chk("rst_busy", 32'(fetch_busy), 32'(0));
    chk("rst_underrun", 32'(underrun), 32'(0));
    chk("rst_rvalid", 32'(host_rvalid), 32'(0));
    step();
    reset = 1'b0; host_valid = 1'b0; host_we = 1'b0; fetch_start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(fetch_busy), 32'(0));
    chk("idle_mem_en", 32'(mem_en), 32'(0));
    step();

    // Basic line fetch: 0x100 + 3*50 = 0x196.
    run_fetch(12'h100, 10'd3, 12'h196, -1, -1, 1'b0, 12'h000, 16'h0000);

    // Host write then read of 0x0AA.
    host_valid = 1'b1; host_we = 1'b1; host_addr = 12'h0AA; host_wdata = 16'h1234;
    @(negedge clk);
    chk("hw_ready", 32'(host_ready), 32'(1));
    chk("hw_mem_en", 32'(mem_en), 32'(1));
    chk("hw_mem_we", 32'(mem_we), 32'(1));
    chk("hw_mem_addr", 32'(mem_addr), 32'h0AA);
    chk("hw_mem_wdata", 32'(mem_wdata), 32'h1234);
    step();
    host_we = 1'b0;
    @(negedge clk);
    chk("hr_ready", 32'(host_ready), 32'(1));
    chk("hr_mem_we", 32'(mem_we), 32'(0));
    chk("hw_no_rvalid", 32'(host_rvalid), 32'(0));
    step();
    host_valid = 1'b0;
    @(negedge clk);
    chk("hr_rvalid", 32'(host_rvalid), 32'(1));
    chk("hr_rdata", 32'(host_rdata), 32'h1234);
    chk("hr_mem_idle", 32'(mem_en), 32'(0));
    step();
    @(negedge clk);
    chk("hr_rvalid_once", 32'(host_rvalid), 32'(0));
    step();

    // Host read collides with fetch_start; granted right after the last issue.
    run_fetch(12'h100, 10'd3, 12'h196, -1, -1, 1'b1, 12'h0AA, 16'h1234);
    // Deadline mid-fetch: 0x100 + 5*50 = 0x1FA, words 0..20 only.
    run_fetch(12'h100, 10'd5, 12'h1FA, 20, -1, 1'b0, 12'h000, 16'h0000);
    // Deadline coincides with the final issue: complete, no underrun.
    run_fetch(12'h100, 10'd3, 12'h196, 49, -1, 1'b0, 12'h000, 16'h0000);
    // Restart while busy is ignored but flagged: 0x200 + 50 = 0x232.
    run_fetch(12'h200, 10'd1, 12'h232, -1, 5, 1'b0, 12'h000, 16'h0000);
    // Address wrap 0xFFF -> 0x000.
    run_fetch(12'hFF0, 10'd0, 12'hFF0, -1, -1, 1'b0, 12'h000, 16'h0000);
    // Line offset truncation: 1023*50 = 0xC7CE -> 0x7CE.
    run_fetch(12'h000, 10'd1023, 12'h7CE, -1, -1, 1'b0, 12'h000, 16'h0000);

    // Deadline while idle has no effect.
    fetch_deadline = 1'b1;
    @(negedge clk);
    chk("idle_deadline_underrun", 32'(underrun), 32'(0));
    chk("idle_deadline_busy", 32'(fetch_busy), 32'(0));
    step();
    fetch_deadline = 1'b0;

    // Reset at cnt=10 drops the pending read.
    base_addr = 12'h100; fetch_line = 10'd3;
    for (int k = 0; k < 10; k++) begin
      fetch_start = (k == 0);
      step();
    end
    fetch_start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_mem_en", 32'(mem_en), 32'(0));
    chk("mid_rst_lb_we", 32'(lb_we), 32'(0));
    chk("mid_rst_busy", 32'(fetch_busy), 32'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_lb_we", 32'(lb_we), 32'(0));
    chk("post_rst_busy", 32'(fetch_busy), 32'(0));
    chk("post_rst_mem_en", 32'(mem_en), 32'(0));
    chk("post_rst_done", 32'(fetch_done), 32'(0));
    step();
    run_fetch(12'h100, 10'd3, 12'h196, -1, -1, 1'b0, 12'h000, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
